controle_multiciclo: RTL and testbench

- Multicycle sequencer for the RISC-V datapath: fetch, decode, execute, memory, writeback.
- Drives the PC, IR, register-file, ALU and data-memory enables, one instruction at a time.
- Replaces single-cycle control decode; shares one memory port between fetch and data access using a mem_ready wait handshake.
- Also keeps a retired-instruction counter and flags illegal tipo/funct3 codes.

---
 rtl/controle_multiciclo_if.sv | 37 +++
 rtl/controle_multiciclo.sv | 187 ++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_multiciclo_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
// The sequencer receives instruction fields and status from the datapath and returns enables.
interface controle_multiciclo_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic [2:0]       tipo;
    logic [2:0]       funct3;
    logic             zero;
    logic             mem_ready;

    logic             pcwrite;
    logic             pcsrc;
    logic             irwrite;
    logic             memread;
    logic             memwrite;
    logic             iord;
    logic             regiwrite;
    logic             memtoreg;
    logic             alusrc;
    logic [3:0]       alucontrol;
    logic [2:0]       estado;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  enable, tipo, funct3, zero, mem_ready,
        output pcwrite, pcsrc, irwrite, memread, memwrite, iord, regiwrite,
               memtoreg, alusrc, alucontrol, estado, illegal, instr_count
    );

    modport slave (
        output enable, tipo, funct3, zero, mem_ready,
        input  pcwrite, pcsrc, irwrite, memread, memwrite, iord, regiwrite,
               memtoreg, alusrc, alucontrol, estado, illegal, instr_count
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V sequencer: FETCH/DECODE/EXEC/MEM/WB sharing one memory port,
// with a retired-instruction counter and a registered illegal-instruction flag.
module controle_multiciclo #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    controle_multiciclo_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] T_LW  = 3'b000;
    localparam logic [2:0] T_SW  = 3'b010;
    localparam logic [2:0] T_R   = 3'b011;
    localparam logic [2:0] T_BEQ = 3'b110;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    state_t           state_q, state_d;
    logic [2:0]       tipo_r_q, tipo_r_d;
    logic [2:0]       funct3_r_q, funct3_r_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             decode_valid;
    logic             retire;

    function automatic logic [3:0] r_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_SUB;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            default: return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            tipo_r_q      <= 3'b000;
            funct3_r_q    <= 3'b000;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            tipo_r_q      <= tipo_r_d;
            funct3_r_q    <= funct3_r_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tipo_r_d     = tipo_r_q;
        funct3_r_d   = funct3_r_q;
        illegal_d    = 1'b0;
        retire       = 1'b0;
        decode_valid = (bus.tipo == T_LW) || (bus.tipo == T_SW) || (bus.tipo == T_BEQ) ||
                       ((bus.tipo == T_R) && ((bus.funct3 == 3'b000) ||
                                              (bus.funct3 == 3'b100) ||
                                              (bus.funct3 == 3'b101)));
        case (state_q)
            S_FETCH: begin
                if (bus.enable && bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                tipo_r_d   = bus.tipo;
                funct3_r_d = bus.funct3;
                if (decode_valid) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (tipo_r_q)
                    T_LW, T_SW: state_d = S_MEM;
                    T_R:        state_d = S_WB;
                    T_BEQ: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    default:    state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // The request stays up until memory acknowledges it.
                if (tipo_r_q == T_LW) begin
                    if (bus.mem_ready) state_d = S_WB;
                end else if (tipo_r_q == T_SW) begin
                    if (bus.mem_ready) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pcsrc       = 1'b0;
        bus.irwrite     = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.iord        = 1'b0;
        bus.regiwrite   = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.alusrc      = 1'b0;
        bus.alucontrol  = 4'b0000;
        bus.illegal     = illegal_q;
        bus.instr_count = instr_count_q;
        bus.estado      = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.enable) begin
                    bus.memread    = 1'b1;
                    bus.alusrc     = 1'b1;
                    bus.alucontrol = ALU_ADD;
                    bus.irwrite    = bus.mem_ready;
                    bus.pcwrite    = bus.mem_ready;
                end
            end
            S_EXEC: begin
                case (tipo_r_q)
                    T_LW, T_SW: begin
                        bus.alusrc     = 1'b1;
                        bus.alucontrol = ALU_ADD;
                    end
                    T_R: bus.alucontrol = r_alu(funct3_r_q);
                    T_BEQ: begin
                        bus.alucontrol = ALU_SUB;
                        bus.pcsrc      = 1'b1;
                        bus.pcwrite    = bus.zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.iord       = 1'b1;
                bus.alusrc     = 1'b1;
                bus.alucontrol = ALU_ADD;
                bus.memread    = (tipo_r_q == T_LW);
                bus.memwrite   = (tipo_r_q == T_SW);
            end
            S_WB: begin
                bus.regiwrite = 1'b1;
                bus.memtoreg  = (tipo_r_q == T_LW);
                // R-type holds the ALU operation so the result being written stays stable.
                if (tipo_r_q == T_R) bus.alucontrol = r_alu(funct3_r_q);
            end
            default: ;
        endcase
        if (reset) begin
            bus.pcwrite     = 1'b0;
            bus.pcsrc       = 1'b0;
            bus.irwrite     = 1'b0;
            bus.memread     = 1'b0;
            bus.memwrite    = 1'b0;
            bus.iord        = 1'b0;
            bus.regiwrite   = 1'b0;
            bus.memtoreg    = 1'b0;
            bus.alusrc      = 1'b0;
            bus.alucontrol  = 4'b0000;
            bus.illegal     = 1'b0;
            bus.instr_count = '0;
        end
    end
endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo (4-bit counter so wrap-around is reachable).
// Observed vector: {estado, pcwrite, pcsrc, irwrite, memread, memwrite, iord, regiwrite, memtoreg, alusrc, alucontrol, illegal}.
module tb_controle_multiciclo;
    localparam int CNT_W = 4;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] XOR = 4'b0011;
    localparam logic [3:0] SRL = 4'b0101;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    controle_multiciclo_if #(.CNT_W(CNT_W)) bus ();

    controle_multiciclo #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] obs();
        return {bus.estado, bus.pcwrite, bus.pcsrc, bus.irwrite, bus.memread, bus.memwrite,
                bus.iord, bus.regiwrite, bus.memtoreg, bus.alusrc, bus.alucontrol, bus.illegal};
    endfunction

    // Flag order: pcwrite pcsrc irwrite memread memwrite iord regiwrite memtoreg alusrc.
    function automatic logic [16:0] ev(input logic [2:0] st, input logic [8:0] fl,
                                       input logic [3:0] alu, input logic ill);
        return {st, fl, alu, ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if (obs() !== ev(3'd0, 9'b0, 4'b0, 1'b0))
            $display("FAIL reset_outputs: got %h want %h", obs(), ev(3'd0, 9'b0, 4'b0, 1'b0));
        else n_pass++;
        n_total++;
        if (bus.instr_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", bus.instr_count);
        else n_pass++;
        $display("reset: estado=%0d outputs=%h", bus.estado, obs());
        tick();
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [16:0] want [5];
        want[0] = ev(3'd0, 9'b101100001, ADD, 1'b0);
        want[1] = ev(3'd1, 9'b000000000, 4'b0, 1'b0);
        want[2] = ev(3'd2, 9'b000000001, ADD, 1'b0);
        want[3] = ev(3'd3, 9'b000101001, ADD, 1'b0);
        want[4] = ev(3'd4, 9'b000000110, 4'b0, 1'b0);
        bus.enable = 1'b1; bus.tipo = 3'b000; bus.funct3 = 3'b000; bus.mem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            n_total++;
            if (obs() !== want[c]) $display("FAIL lw_cycle%0d: got %h want %h", c, obs(), want[c]);
            else n_pass++;
            tick();
        end
        exp_cnt++;
        #2;
        n_total++;
        if ({bus.estado, bus.instr_count} !== {3'd0, exp_cnt})
            $display("FAIL lw_retire: got estado=%0d cnt=%0d want estado=0 cnt=%0d", bus.estado, bus.instr_count, exp_cnt);
        else n_pass++;
        $display("lw: retired, instr_count=%0d", bus.instr_count);
    endtask

    task automatic test_sw_wait();
        logic [16:0] want;
        bus.tipo = 3'b010; bus.mem_ready = 1'b1;
        want = ev(3'd0, 9'b101100001, ADD, 1'b0);
        #2; n_total++;
        if (obs() !== want) $display("FAIL sw_fetch: got %h want %h", obs(), want); else n_pass++;
        tick(); tick();
        want = ev(3'd2, 9'b000000001, ADD, 1'b0);
        #2; n_total++;
        if (obs() !== want) $display("FAIL sw_exec: got %h want %h", obs(), want); else n_pass++;
        tick();
        want = ev(3'd3, 9'b000011001, ADD, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            #2; n_total++;
            if (obs() !== want) $display("FAIL sw_mem%0d: got %h want %h", i, obs(), want); else n_pass++;
            tick();
        end
        bus.mem_ready = 1'b1;
        exp_cnt++;
        #2; n_total++;
        if ({bus.estado, bus.instr_count} !== {3'd0, exp_cnt})
            $display("FAIL sw_retire: got estado=%0d cnt=%0d want estado=0 cnt=%0d", bus.estado, bus.instr_count, exp_cnt);
        else n_pass++;
        $display("sw: 3 wait cycles, instr_count=%0d", bus.instr_count);
    endtask

    task automatic test_rtype();
        logic [2:0]  f3s  [3];
        logic [3:0]  alus [3];
        logic [16:0] want;
        f3s[0] = 3'b000; alus[0] = SUB;
        f3s[1] = 3'b100; alus[1] = XOR;
        f3s[2] = 3'b101; alus[2] = SRL;
        for (int k = 0; k < 3; k++) begin
            bus.tipo = 3'b011; bus.funct3 = f3s[k];
            if (k == 0) begin
                bus.mem_ready = 1'b0;
                want = ev(3'd0, 9'b000100001, ADD, 1'b0);
                #2; n_total++;
                if (obs() !== want) $display("FAIL fetch_wait: got %h want %h", obs(), want); else n_pass++;
                tick();
                bus.mem_ready = 1'b1;
            end
            tick();
            want = ev(3'd1, 9'b0, 4'b0, 1'b0);
            #2; n_total++;
            if (obs() !== want) $display("FAIL r%0d_decode: got %h want %h", k, obs(), want); else n_pass++;
            tick();
            // Scramble IR fields: EXEC/WB must use the latched copies.
            bus.tipo = 3'b111; bus.funct3 = 3'b111;
            want = ev(3'd2, 9'b000000000, alus[k], 1'b0);
            #2; n_total++;
            if (obs() !== want) $display("FAIL r%0d_exec: got %h want %h", k, obs(), want); else n_pass++;
            tick();
            want = ev(3'd4, 9'b000000100, alus[k], 1'b0);
            #2; n_total++;
            if (obs() !== want) $display("FAIL r%0d_wb: got %h want %h", k, obs(), want); else n_pass++;
            tick();
            exp_cnt++;
            n_total++;
            if (bus.instr_count !== exp_cnt) $display("FAIL r%0d_count: got %0d want %0d", k, bus.instr_count, exp_cnt);
            else n_pass++;
            $display("rtype funct3=%b: alucontrol=%b, instr_count=%0d", f3s[k], alus[k], bus.instr_count);
        end
    endtask

    task automatic test_illegal();
        logic [16:0] want;
        bus.tipo = 3'b011; bus.funct3 = 3'b001;
        tick();
        want = ev(3'd1, 9'b0, 4'b0, 1'b0);
        #2; n_total++;
        if (obs() !== want) $display("FAIL ill_decode: got %h want %h", obs(), want); else n_pass++;
        tick();
        bus.enable = 1'b0;
        want = ev(3'd0, 9'b0, 4'b0, 1'b1);
        #2; n_total++;
        if (obs() !== want) $display("FAIL ill_pulse: got %h want %h", obs(), want); else n_pass++;
        n_total++;
        if (bus.instr_count !== exp_cnt) $display("FAIL ill_count: got %0d want %0d", bus.instr_count, exp_cnt);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            want = ev(3'd0, 9'b0, 4'b0, 1'b0);
            #2; n_total++;
            if (obs() !== want) $display("FAIL idle%0d: got %h want %h", i, obs(), want); else n_pass++;
        end
        $display("illegal: pulse seen, idle with enable=0, instr_count=%0d", bus.instr_count);
        tick();
        bus.enable = 1'b1;
    endtask

    task automatic test_beq();
        logic [16:0] want;
        for (int z = 1; z >= 0; z--) begin
            bus.tipo = 3'b110; bus.zero = z[0];
            tick(); tick();
            want = ev(3'd2, (z == 1) ? 9'b110000000 : 9'b010000000, SUB, 1'b0);
            #2; n_total++;
            if (obs() !== want) $display("FAIL beq_z%0d_exec: got %h want %h", z, obs(), want); else n_pass++;
            tick();
            exp_cnt++;
            n_total++;
            if ({bus.estado, bus.instr_count} !== {3'd0, exp_cnt})
                $display("FAIL beq_z%0d_retire: got estado=%0d cnt=%0d want 0/%0d", z, bus.estado, bus.instr_count, exp_cnt);
            else n_pass++;
            $display("beq zero=%0d: retired in 3 cycles, instr_count=%0d", z, bus.instr_count);
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_enable_mid();
        logic [16:0] want;
        bus.tipo = 3'b000; bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        tick(); tick();
        want = ev(3'd3, 9'b000101001, ADD, 1'b0);
        #2; n_total++;
        if (obs() !== want) $display("FAIL en_mem: got %h want %h", obs(), want); else n_pass++;
        tick();
        want = ev(3'd4, 9'b000000110, 4'b0, 1'b0);
        #2; n_total++;
        if (obs() !== want) $display("FAIL en_wb: got %h want %h", obs(), want); else n_pass++;
        tick();
        exp_cnt++;
        for (int i = 0; i < 2; i++) begin
            want = ev(3'd0, 9'b0, 4'b0, 1'b0);
            #2; n_total++;
            if (obs() !== want) $display("FAIL en_idle%0d: got %h want %h", i, obs(), want); else n_pass++;
            tick();
        end
        n_total++;
        if (bus.instr_count !== exp_cnt) $display("FAIL en_count: got %0d want %0d", bus.instr_count, exp_cnt);
        else n_pass++;
        $display("enable dropped mid-lw: completed, instr_count=%0d", bus.instr_count);
        bus.enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [16:0] want;
        bus.tipo = 3'b010; bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        want = ev(3'd3, 9'b000011001, ADD, 1'b0);
        #2; n_total++;
        if (obs() !== want) $display("FAIL rst_mem: got %h want %h", obs(), want); else n_pass++;
        tick();
        reset = 1'b1;
        want = ev(3'd3, 9'b0, 4'b0, 1'b0);
        #2; n_total++;
        if (obs() !== want) $display("FAIL rst_force: got %h want %h", obs(), want); else n_pass++;
        tick();
        reset = 1'b0; bus.mem_ready = 1'b1;
        exp_cnt = '0;
        #2; n_total++;
        if ({bus.estado, bus.instr_count} !== {3'd0, exp_cnt})
            $display("FAIL rst_after: got estado=%0d cnt=%0d want 0/0", bus.estado, bus.instr_count);
        else n_pass++;
        $display("reset during sw MEM: abandoned, instr_count=%0d", bus.instr_count);
    endtask

    task automatic test_back_to_back();
        bus.tipo = 3'b011; bus.funct3 = 3'b100; bus.mem_ready = 1'b1; bus.enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(); tick(); tick(); tick();
            exp_cnt++;
            n_total++;
            if ({bus.estado, bus.instr_count} !== {3'd0, exp_cnt})
                $display("FAIL b2b_%0d: got estado=%0d cnt=%0d want 0/%0d", i, bus.estado, bus.instr_count, exp_cnt);
            else n_pass++;
            $display("back_to_back r-type %0d: instr_count=%0d", i, bus.instr_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b1; bus.tipo = 3'b000; bus.funct3 = 3'b000;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;
        tick();
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_illegal();
        test_beq();
        test_enable_mid();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
